ram_word_uart_streamer: RTL and testbench
=========================================

Name: ram_word_uart_streamer

Overview:
- Downstream of the send-select stage. On a one-cycle send request it reads 32-bit words from the correlator RAM port over an inclusive address range, start_addr to end_addr.
- Each word is serialised as four bytes onto an 8N1 UART line.
- When the last stop bit completes, it pulses ok, which the send-select state machine waits on before returning to idle.
- A test transfer is start_addr = end_addr = 0, with the data mux supplying the constant word.

Parameters:
BAUD_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
RD_LAT, 1, cycles from the read-strobe cycle to the cycle where data is valid; legal range 1..4

Ports:
clk  input  1  system clock, 50 MHz; all logic on the rising edge
rst  input  1  synchronous, active-high reset
send_sig  input  1  single-cycle transfer request
start_addr  input  16  first word address; sampled only when send_sig is accepted
end_addr  input  16  last word address, inclusive; sampled only when send_sig is accepted
read  output  1  one-cycle RAM read strobe per word
addr  output  16  current word address; held stable from the read strobe until the word's last stop bit
data  input  32  word for addr; sampled RD_LAT cycles after read
rs232_tx  output  1  UART serial out; idle high
ok  output  1  one-cycle pulse when the transfer completes
busy  output  1  high from acceptance until the cycle ok pulses, inclusive

Behaviour:
- Reset (rst high at a clock edge) is synchronous and active-high. Outputs go to: read=0, addr=0, rs232_tx=1, ok=0, busy=0; the FSM goes to IDLE. This applies at any point, including mid-bit or mid-word. Any partial frame is abandoned; no ok is produced.
- States: IDLE, RDREQ, RDWAIT, LOAD, TXBIT, NEXTBYTE, NEXTWORD, DONE.
- IDLE:
  - send_sig=1 is accepted. Latch start_addr into addr and end_addr into end_reg; busy rises next cycle; go to RDREQ.
  - send_sig is ignored in every other state; no queuing.
- RDREQ: read=1 for exactly this cycle; go to RDWAIT.
- RDWAIT: count RD_LAT-1 cycles (zero cycles when RD_LAT=1); go to LOAD.
- LOAD:
  - Capture data into word_reg and set byte index = 0.
  - Load the shift frame: start bit 0, byte[7:0], stop bit 1. Go to TXBIT.
- TXBIT:
  - rs232_tx drives the current frame bit for exactly BAUD_DIV cycles per bit.
  - Bit order: start, d0..d7 (LSB first), stop. That is 10 bits, 10*BAUD_DIV cycles per byte.
- Byte order is least-significant byte first. The constant 32'h00134b4f is sent as 4F, 4B, 13, 00.
- NEXTBYTE (entered after the stop bit period ends):
  - If byte index < 3: increment it, load the next byte frame, and return to TXBIT in the same cycle. There is no idle gap between bytes.
  - Otherwise go to NEXTWORD.
- NEXTWORD:
  - If addr == end_reg, or addr > end_reg (reversed range): go to DONE. A reversed range therefore sends exactly one word, at start_addr.
  - Otherwise addr <= addr + 1 and go to RDREQ.
- Address arithmetic: addr is 16-bit unsigned. The equality check happens before the increment, so end_addr = 16'hFFFF terminates without wrapping. Full range 0000..FFFF yields 65536 words.
- DONE: ok=1 for one cycle; busy falls the next cycle; go to IDLE. A new send_sig is accepted on the cycle after ok.
- Inter-word gap: 3 + RD_LAT cycles of idle-high line between a word's last stop bit and the next start bit.
- rs232_tx is registered, with no combinational path from any input.

Test Plan:
1. Single word, with BAUD_DIV=4, RD_LAT=1: send_sig with start=end=0, RAM returns 32'h00134b4f. Required response:
   - read pulses once with addr=0.
   - The line carries 4F, 4B, 13, 00 in 8N1, each bit 4 cycles.
   - ok pulses once, exactly 160 cycles after the first start bit edge.
2. Range: start=16'h1000, end=16'h101F, RAM returns addr-dependent data. Required response:
   - 32 read strobes at addresses 1000..101F, in order.
   - 128 bytes decoded, matching the data.
   - A single ok, after the 128th stop bit.
3. RD_LAT=3 and a reversed range (start=16'h2005, end=16'h2000): exactly one word, from 2005, is sent. data is sampled 3 cycles after read, and data changes outside that cycle have no effect.
4. Busy rejection: a second send_sig, with different addresses, pulsed mid-transfer is ignored. Only the first range is sent, busy stays high throughout, and only one ok is produced.
5. Reset mid-byte: rst asserted during bit d3 of byte 2. Required response:
   - rs232_tx=1, busy=0, ok=0 on the next cycle.
   - No ok afterwards.
   - A fresh send_sig then sends a complete, correct word.
6. Top-of-memory: start=16'hFFFE, end=16'hFFFF sends exactly 2 words. addr never wraps to 0000, and ok pulses once.

Source files
------------

// File: rtl/ram_word_uart_streamer.sv
// Reads an inclusive range of 32-bit RAM words and streams each one out of an 8N1 UART
// line, least-significant byte first. Pulses ok once the final stop bit has completed.
module ram_word_uart_streamer #(
  parameter int BAUD_DIV = 434,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_sig,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  output logic        read,
  output logic [15:0] addr,
  input  logic [31:0] data,
  output logic        rs232_tx,
  output logic        ok,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, RDREQ, RDWAIT, LOAD, TXBIT, NEXTBYTE, NEXTWORD, DONE
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [1:0]  WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t      r_state, w_next;
  logic [15:0] r_addr;
  logic [15:0] r_end;
  logic [23:0] r_word_hi;
  logic [1:0]  r_byte_idx;
  logic [9:0]  r_frame;
  logic [3:0]  r_bit_idx;
  logic [15:0] r_baud_cnt;
  logic [1:0]  r_wait_cnt;
  logic        w_bit_end;
  logic        w_frame_end;
  logic        w_last_byte;
  logic        w_last_word;

  assign w_bit_end   = (r_baud_cnt == 16'd0);
  assign w_frame_end = w_bit_end && (r_bit_idx == 4'd9);
  assign w_last_byte = (r_byte_idx == 2'd3);
  // Equal-or-past covers a reversed range and stops at FFFF before any wrap.
  assign w_last_word = (r_addr >= r_end);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Bytes of one word run back to back: the next frame is loaded on the last stop-bit
  // cycle. Only a word boundary visits NEXTBYTE/NEXTWORD, and the final word goes
  // straight to DONE so ok lands on the first cycle after its last stop bit.
  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      IDLE:     if (send_sig) w_next = RDREQ;
      RDREQ:    w_next = (RD_LAT > 1) ? RDWAIT : LOAD;
      RDWAIT:   if (r_wait_cnt == 2'd0) w_next = LOAD;
      LOAD:     w_next = TXBIT;
      TXBIT:    if (w_frame_end && w_last_byte) w_next = w_last_word ? DONE : NEXTBYTE;
      NEXTBYTE: w_next = NEXTWORD;
      NEXTWORD: w_next = w_last_word ? DONE : RDREQ;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_end      <= '0;
      r_word_hi  <= '0;
      r_byte_idx <= '0;
      r_frame    <= '1;
      r_bit_idx  <= '0;
      r_baud_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, like real flops.
      case (r_state)
        IDLE: begin
          if (send_sig) begin
            r_addr <= start_addr;
            r_end  <= end_addr;
          end
        end
        RDREQ:  r_wait_cnt <= WAIT_LAST;
        RDWAIT: r_wait_cnt <= r_wait_cnt - 2'd1;
        LOAD: begin
          r_word_hi  <= data[31:8];
          r_byte_idx <= 2'd0;
          r_frame    <= {1'b1, data[7:0], 1'b0};
          r_bit_idx  <= 4'd0;
          r_baud_cnt <= BAUD_LAST;
        end
        TXBIT: begin
          if (w_bit_end) begin
            r_baud_cnt <= BAUD_LAST;
            if (r_bit_idx == 4'd9) begin
              if (!w_last_byte) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_frame    <= {1'b1, r_word_hi[7:0], 1'b0};
                r_word_hi  <= {8'h00, r_word_hi[23:8]};
                r_bit_idx  <= 4'd0;
              end
            end else begin
              r_frame   <= {1'b1, r_frame[9:1]};
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
          end
        end
        NEXTWORD: if (!w_last_word) r_addr <= r_addr + 16'd1;
        default: ;
      endcase
    end
  end

  // Bit 0 of the frame register is the line itself, refilled with ones as it shifts.
  assign rs232_tx = r_frame[0];
  assign addr     = r_addr;
  assign read     = (r_state == RDREQ);
  assign ok       = (r_state == DONE);
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ram_word_uart_streamer.sv
// Bench for ram_word_uart_streamer: two instances (RD_LAT 1 and 3) driven from a vector
// table, with queued expected addresses/bytes compared as the DUT emits them.
module tb_ram_word_uart_streamer;

  localparam int BAUD = 4;
  localparam int HALF = BAUD / 2;

  typedef struct {
    logic        sel;       // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
    logic [15:0] sa;
    logic [15:0] ea;
    int          words;     // expected words on the line
    int          ok_delay;  // cycles from first start-bit edge to ok
    int          intrude;   // cycle after send to pulse a rogue send_sig, -1 for none
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] start_addr, end_addr;
  logic        send0, send1;
  logic        read0, read1;
  logic [15:0] addr0, addr1;
  logic [31:0] data0, data1;
  logic        tx0, tx1, ok0, ok1, busy0, busy1;

  always #5 clk = ~clk;

  ram_word_uart_streamer #(.BAUD_DIV(BAUD), .RD_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .send_sig(send0), .start_addr(start_addr), .end_addr(end_addr),
    .read(read0), .addr(addr0), .data(data0), .rs232_tx(tx0), .ok(ok0), .busy(busy0)
  );

  ram_word_uart_streamer #(.BAUD_DIV(BAUD), .RD_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .send_sig(send1), .start_addr(start_addr), .end_addr(end_addr),
    .read(read1), .addr(addr1), .data(data1), .rs232_tx(tx1), .ok(ok1), .busy(busy1)
  );

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h00134b4f;
    return {a ^ 16'h5AC3, ~a} + 32'h0101_0101;
  endfunction

  // RAM models: valid data only in the cycle RD_LAT after the strobe, noise otherwise.
  logic [4:0]  rd_h0 = '0;
  logic [4:0]  rd_h1 = '0;
  logic [15:0] ad_h0 [5];
  logic [15:0] ad_h1 [5];

  always @(negedge clk) begin
    rd_h0 = {rd_h0[3:0], read0};
    for (int k = 4; k > 0; k--) ad_h0[k] = ad_h0[k-1];
    ad_h0[0] = addr0;
    data0 = rd_h0[1] ? ram_word(ad_h0[1]) : $urandom;
  end

  always @(negedge clk) begin
    rd_h1 = {rd_h1[3:0], read1};
    for (int k = 4; k > 0; k--) ad_h1[k] = ad_h1[k-1];
    ad_h1[0] = addr1;
    data1 = rd_h1[3] ? ram_word(ad_h1[3]) : $urandom;
  end

  logic        sel = 1'b0;
  logic        m_read, m_tx, m_ok, m_busy;
  logic [15:0] m_addr;
  assign m_read = sel ? read1 : read0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_tx   = sel ? tx1   : tx0;
  assign m_ok   = sel ? ok1   : ok0;
  assign m_busy = sel ? busy1 : busy0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b0;
  logic        xfer_active = 1'b0;
  int          ok_seen = 0, ok_cyc = 0, first_start_cyc = -1;
  int          busy_low = 0, out_of_range = 0;
  logic [15:0] lo = '0, hi = '0;
  logic        u_active = 1'b0;
  int          u_cnt = 0;
  logic [7:0]  u_byte = '0;
  logic [15:0] exp_addr_q [$];
  logic [7:0]  exp_byte_q [$];
  vec_t        vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_step();
    if (!mon_en) return;
    if (m_read) begin
      if (exp_addr_q.size() == 0) check("read_unexpected", 32'(m_addr), 32'hFFFF_FFFF);
      else check("read_addr", 32'(m_addr), 32'(exp_addr_q.pop_front()));
    end
    if (xfer_active) begin
      if (!m_busy) busy_low++;
      if (m_addr < lo || m_addr > hi) out_of_range++;
    end
    if (m_ok) begin
      ok_seen++;
      ok_cyc = cyc;
      check("busy_with_ok", 32'(m_busy), 32'd1);
      xfer_active = 1'b0;
    end
    if (!u_active) begin
      if (!m_tx) begin
        u_active = 1'b1;
        u_cnt    = 0;
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end
    end else begin
      u_cnt++;
      if (u_cnt == HALF) begin
        check("uart_start", 32'(m_tx), 32'd0);
      end else if (u_cnt == 9 * BAUD + HALF) begin
        check("uart_stop", 32'(m_tx), 32'd1);
        if (exp_byte_q.size() == 0) check("uart_extra_byte", 32'(u_byte), 32'h1FF);
        else check("uart_byte", 32'(u_byte), 32'(exp_byte_q.pop_front()));
        u_active = 1'b0;
      end else if (u_cnt % BAUD == HALF) begin
        u_byte = {m_tx, u_byte[7:1]};
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor_step();
  endtask

  task automatic start_vector(input vec_t v, output int ok_before);
    logic [15:0] aw;
    logic [31:0] wd;
    for (int w = 0; w < v.words; w++) begin
      aw = v.sa + 16'(w);
      wd = ram_word(aw);
      exp_addr_q.push_back(aw);
      for (int b = 0; b < 4; b++) exp_byte_q.push_back(wd[8*b +: 8]);
    end
    sel = v.sel;
    start_addr = v.sa;
    end_addr   = v.ea;
    lo = v.sa;
    hi = (v.ea >= v.sa) ? v.ea : v.sa;
    first_start_cyc = -1;
    busy_low = 0;
    out_of_range = 0;
    ok_before = ok_seen;
    if (v.sel) send1 = 1'b1;
    else       send0 = 1'b1;
    tick();
    send0 = 1'b0;
    send1 = 1'b0;
    xfer_active = 1'b1;
  endtask

  task automatic finish_vector(input vec_t v, input int ok_before);
    int n = 0;
    while (ok_seen == ok_before && n < 20000) begin
      if (n == v.intrude) begin
        start_addr = 16'h4000;
        end_addr   = 16'h4005;
        if (v.sel) send1 = 1'b1;
        else       send0 = 1'b1;
      end
      tick();
      send0 = 1'b0;
      send1 = 1'b0;
      n++;
    end
    check("ok_timeout", 32'(ok_seen != ok_before), 32'd1);
    check("ok_delay", 32'(ok_cyc - first_start_cyc), 32'(v.ok_delay));
    repeat (60) tick();
    check("ok_count", 32'(ok_seen - ok_before), 32'd1);
    check("busy_gap", 32'(busy_low), 32'd0);
    check("busy_after", 32'(m_busy), 32'd0);
    check("addr_range", 32'(out_of_range), 32'd0);
    check("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
    check("byte_q_left", 32'(exp_byte_q.size()), 32'd0);
  endtask

  initial begin
    int   okb;
    int   n;
    vec_t fresh;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1,  160,  -1};   // constant test word
    vecs[1] = '{1'b0, 16'h1000, 16'h101F, 32, 5244, -1};   // 32*160 + 31*(3+1)
    vecs[2] = '{1'b1, 16'h2005, 16'h2000, 1,  160,  -1};   // reversed, RD_LAT=3
    vecs[3] = '{1'b0, 16'hFFFE, 16'hFFFF, 2,  324,  -1};   // top of memory
    vecs[4] = '{1'b1, 16'h3000, 16'h3001, 2,  326,  100};  // rogue send mid-transfer

    rst = 1'b1;
    send0 = 1'b0;
    send1 = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    repeat (3) tick();
    check("rst_read", 32'(read0), 32'd0);
    check("rst_addr", 32'(addr0), 32'd0);
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_ok", 32'(ok0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_tx_lat3", 32'(tx1), 32'd1);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start_vector(vecs[i], okb);
      finish_vector(vecs[i], okb);
    end

    // Reset during d3 of byte 2 (frame cycles 96..99 after the first start edge).
    fresh = '{1'b0, 16'h0050, 16'h0050, 1, 160, -1};
    start_vector(fresh, okb);
    n = 0;
    while (!(first_start_cyc >= 0 && cyc >= first_start_cyc + 97) && n < 3000) begin
      tick();
      n++;
    end
    check("reset_point_timeout", 32'(n < 3000), 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    check("midrst_tx", 32'(m_tx), 32'd1);
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_ok", 32'(m_ok), 32'd0);
    rst = 1'b0;
    xfer_active = 1'b0;
    u_active = 1'b0;
    exp_addr_q.delete();
    exp_byte_q.delete();
    mon_en = 1'b1;
    okb = ok_seen;
    repeat (200) tick();
    check("ok_after_reset", 32'(ok_seen - okb), 32'd0);
    check("busy_after_reset", 32'(m_busy), 32'd0);

    fresh = '{1'b0, 16'h0051, 16'h0051, 1, 160, -1};
    start_vector(fresh, okb);
    finish_vector(fresh, okb);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
